text_console: RTL and testbench

- Character-stream writer for the 80x25 text-mode frame buffer that the video scanout block displays.
- Accepts bytes over a valid/ready handshake and writes character/attribute pairs into video memory.
- Interprets CR, LF, BS and FF control codes, scrolls the screen up one row when output passes the last row, and drives the cursor position consumed by the display.

---
 rtl/text_console_if.sv | 23 ++
 rtl/text_console.sv | 196 +++++++++++++++++++
 tb/tb_text_console.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Byte-stream input and video-memory port of the text console.
// master: the byte source plus the synchronous video RAM.
// slave:  the console itself.
interface text_console_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [7:0]  in_attr;
   logic        in_ready;
   logic [16:0] mem_address;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   modport master (
      output in_valid, in_data, in_attr, mem_rdata,
      input  in_ready, mem_address, mem_wdata, mem_we
   );

   modport slave (
      input  in_valid, in_data, in_attr, mem_rdata,
      output in_ready, mem_address, mem_wdata, mem_we
   );
endinterface

// File: rtl/text_console.sv
// Character-stream writer for the 80x25 text frame buffer.
// Prints char/attr pairs, handles CR/LF/BS/FF, scrolls up one row past the
// last row and exports the display cursor (cell index - 1).
module text_console #(
   parameter logic [16:0] BASE = 17'h0F000,
   parameter int          COLS = 80,
   parameter int          ROWS = 25,
   parameter logic [7:0]  FILL = 8'h20
) (
   input  logic          clock,
   input  logic          reset,
   text_console_if.slave bus,
   output logic [10:0]   cursor,
   output logic          busy
);

   localparam logic [6:0]  LAST_COL     = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW     = 5'(ROWS - 1);
   localparam logic [11:0] SCR_LAST     = 12'(2 * COLS * (ROWS - 1) - 1);
   localparam logic [11:0] CLR_LAST     = 12'(2 * COLS - 1);
   localparam logic [11:0] CLS_LAST     = 12'(2 * COLS * ROWS - 1);
   localparam logic [16:0] ROW_BYTES    = 17'(2 * COLS);
   localparam logic [16:0] LAST_ROW_OFS = 17'(2 * COLS * (ROWS - 1));

   typedef enum logic [2:0] {
      IDLE,
      PUT_CHR,
      PUT_ATR,
      SCR_RD,
      SCR_WR,
      CLR,
      CLS
   } state_t;

   state_t      state_reg, state_next;
   logic [6:0]  col_reg, col_next;
   logic [4:0]  row_reg, row_next;
   logic [11:0] k_reg, k_next;
   logic [7:0]  chr_reg, chr_next;
   logic [7:0]  attr_reg, attr_next;

   logic [10:0] id;
   logic [16:0] cell_addr;
   logic [16:0] k_ext;
   logic [7:0]  fill_byte;
   logic [16:0] addr;
   logic [7:0]  wdata;
   logic        we;

   assign id        = 11'(32'(row_reg) * COLS + 32'(col_reg));
   assign cell_addr = BASE + {5'b0, id, 1'b0};
   assign k_ext     = {5'b0, k_reg};
   // Cleared cells alternate fill character (even byte) and attribute (odd byte).
   assign fill_byte = k_reg[0] ? attr_reg : FILL;

   assign cursor          = id - 11'd1;
   assign busy            = (state_reg != IDLE);
   assign bus.in_ready    = (state_reg == IDLE);
   assign bus.mem_address = addr;
   assign bus.mem_wdata   = wdata;
   assign bus.mem_we      = we;

   // State and position registers; reset aborts any operation in progress.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         col_reg   <= '0;
         row_reg   <= '0;
         k_reg     <= '0;
         chr_reg   <= '0;
         attr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
         k_reg     <= k_next;
         chr_reg   <= chr_next;
         attr_reg  <= attr_next;
      end
   end

   // Next-state logic and memory-port outputs.
   always_comb begin
      state_next = state_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      k_next     = k_reg;
      chr_next   = chr_reg;
      attr_next  = attr_reg;
      addr       = '0;
      wdata      = '0;
      we         = 1'b0;

      case (state_reg)
         IDLE: begin
            // in_ready is high whenever IDLE, so in_valid alone means a transfer.
            if (bus.in_valid) begin
               chr_next  = bus.in_data;
               attr_next = bus.in_attr;
               case (bus.in_data)
                  8'h0D: col_next = '0;
                  8'h08: begin
                     if (col_reg != '0) col_next = col_reg - 7'd1;
                  end
                  8'h0A: begin
                     if (row_reg < LAST_ROW) begin
                        row_next = row_reg + 5'd1;
                     end else begin
                        state_next = SCR_RD;
                        k_next     = '0;
                     end
                  end
                  8'h0C: begin
                     state_next = CLS;
                     k_next     = '0;
                  end
                  default: state_next = PUT_CHR;
               endcase
            end
         end

         PUT_CHR: begin
            addr       = cell_addr;
            wdata      = chr_reg;
            we         = 1'b1;
            state_next = PUT_ATR;
         end

         PUT_ATR: begin
            addr  = cell_addr + 17'd1;
            wdata = attr_reg;
            we    = 1'b1;
            if (col_reg < LAST_COL) begin
               col_next   = col_reg + 7'd1;
               state_next = IDLE;
            end else begin
               col_next = '0;
               if (row_reg < LAST_ROW) begin
                  row_next   = row_reg + 5'd1;
                  state_next = IDLE;
               end else begin
                  state_next = SCR_RD;
                  k_next     = '0;
               end
            end
         end

         SCR_RD: begin
            // Read one row ahead; data arrives next cycle from the synchronous RAM.
            addr       = BASE + ROW_BYTES + k_ext;
            state_next = SCR_WR;
         end

         SCR_WR: begin
            addr  = BASE + k_ext;
            wdata = bus.mem_rdata;
            we    = 1'b1;
            if (k_reg == SCR_LAST) begin
               state_next = CLR;
               k_next     = '0;
            end else begin
               state_next = SCR_RD;
               k_next     = k_reg + 12'd1;
            end
         end

         CLR: begin
            // Blank the freshly exposed bottom row; row/col already hold their final values.
            addr  = BASE + LAST_ROW_OFS + k_ext;
            wdata = fill_byte;
            we    = 1'b1;
            if (k_reg == CLR_LAST) begin
               state_next = IDLE;
            end else begin
               k_next = k_reg + 12'd1;
            end
         end

         CLS: begin
            addr  = BASE + k_ext;
            wdata = fill_byte;
            we    = 1'b1;
            if (k_reg == CLS_LAST) begin
               state_next = IDLE;
               col_next   = '0;
               row_next   = '0;
            end else begin
               k_next = k_reg + 12'd1;
            end
         end

         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_text_console.sv
// Scoreboard bench for text_console: stimulus pushes expected memory writes,
// a negedge monitor pops and compares every write the console issues.
module tb_text_console;

   localparam logic [16:0] BASE = 17'h0F000;

   typedef struct packed {
      logic [16:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] cursor;
   logic        busy;

   text_console_if bus ();

   text_console dut (
      .clock  (clock),
      .reset  (reset),
      .bus    (bus),
      .cursor (cursor),
      .busy   (busy)
   );

   always #20 clock = ~clock;

   int  n_vec = 0;
   int  n_err = 0;
   wr_t exp_q[$];

   logic [7:0] ram [0:131071];

   // Synchronous video RAM.
   always @(posedge clock) begin
      if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_address];
   end

   // Monitor: every write strobe must match the next expected write.
   always @(negedge clock) begin
      if (bus.mem_we === 1'b1) begin
         wr_t e;
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got %05h<-%02h, required no write", bus.mem_address, bus.mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if (bus.mem_address !== e.a || bus.mem_wdata !== e.d) begin
               n_err++;
               $display("FAIL mem_write: got %05h<-%02h, required %05h<-%02h", bus.mem_address, bus.mem_wdata, e.a, e.d);
            end
         end
      end
   end

   initial begin
      #(40 * 60000);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   function automatic void push_wr(input logic [16:0] a, input logic [7:0] d);
      exp_q.push_back('{a: a, d: d});
   endfunction

   function automatic void push_put(input int id, input logic [7:0] c, input logic [7:0] at);
      push_wr(BASE + 17'(2 * id), c);
      push_wr(BASE + 17'(2 * id + 1), at);
   endfunction

   task automatic send(input logic [7:0] d, input logic [7:0] a);
      int t = 0;
      @(negedge clock);
      while (bus.in_ready !== 1'b1 && t < 20000) begin
         @(negedge clock);
         t++;
      end
      if (t >= 20000) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_attr  = a;
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
      bus.in_attr  = ~a;
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      @(negedge clock);
      while (busy === 1'b1 && cycles < 20000) begin
         cycles++;
         @(negedge clock);
      end
      if (cycles >= 20000) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: busy stayed %b, required 0", busy);
      end
   endtask

   initial begin
      int cyc;
      int t;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_attr  = 8'h00;
      for (int i = 0; i < 131072; i++) ram[i] = 8'h00;

      // Reset state
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("reset_cursor", 32'(cursor), 32'h7FF);
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_mem_we", 32'(bus.mem_we), 32'd0);
      check("reset_mem_address", 32'(bus.mem_address), 32'd0);

      // 'A' at cell 0: two writes, in_ready low for exactly two cycles
      push_put(0, 8'h41, 8'h1F);
      send(8'h41, 8'h1F);
      @(negedge clock);
      check("A_ready_cyc1", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
      check("A_ready_cyc2", 32'(bus.in_ready), 32'd0);
      @(negedge clock);
      check("A_ready_cyc3", 32'(bus.in_ready), 32'd1);
      check("A_cursor", 32'(cursor), 32'h000);

      // Rest of row 0 (cells 1..79), wraps to row 1 col 0
      for (int i = 1; i < 80; i++) begin
         push_put(i, 8'(8'h30 + i), 8'h1F);
         send(8'(8'h30 + i), 8'h1F);
      end
      wait_idle(cyc);
      check("row0_full_cursor", 32'(cursor), 32'd79);

      // CR and BS at col 0: no change, no writes, in_ready stays high
      send(8'h0D, 8'h00);
      check("cr_ready", 32'(bus.in_ready), 32'd1);
      check("cr_cursor", 32'(cursor), 32'd79);
      send(8'h08, 8'h00);
      check("bs_col0_ready", 32'(bus.in_ready), 32'd1);
      check("bs_col0_cursor", 32'(cursor), 32'd79);

      // Reach row 3 col 5, then LF keeps the column
      send(8'h0A, 8'h00);
      send(8'h0A, 8'h00);
      check("lf_row3_cursor", 32'(cursor), 32'd239);
      for (int i = 0; i < 5; i++) begin
         push_put(240 + i, 8'(8'h61 + i), 8'h2A);
         send(8'(8'h61 + i), 8'h2A);
      end
      wait_idle(cyc);
      check("row3_col5_cursor", 32'(cursor), 32'd244);
      send(8'h0A, 8'h00);
      check("lf_row4_col5_cursor", 32'(cursor), 32'd324);
      send(8'h08, 8'h00);
      check("bs_col5_cursor", 32'(cursor), 32'd323);
      send(8'h0D, 8'h00);
      check("cr_row4_cursor", 32'(cursor), 32'd319);

      // Move to row 24 col 79
      for (int i = 0; i < 20; i++) send(8'h0A, 8'h00);
      check("lf_row24_cursor", 32'(cursor), 32'd1919);
      for (int i = 0; i < 79; i++) begin
         push_put(1920 + i, 8'h2E, 8'h0E);
         send(8'h2E, 8'h0E);
      end
      wait_idle(cyc);
      check("row24_col79_cursor", 32'(cursor), 32'd1998);

      // Preload: char = row number, attr = row ^ 0x80
      for (int id = 0; id < 2000; id++) begin
         ram[BASE + 17'(2 * id)]     = 8'(id / 80);
         ram[BASE + 17'(2 * id + 1)] = 8'(id / 80) ^ 8'h80;
      end

      // 'Z' at the last cell triggers a scroll
      push_put(1999, 8'h5A, 8'h4E);
      for (int k = 0; k < 3840; k++) begin
         int src;
         src = (160 + k) / 2;
         if (src == 1999) push_wr(BASE + 17'(k), (k % 2 == 0) ? 8'h5A : 8'h4E);
         else             push_wr(BASE + 17'(k), (k % 2 == 0) ? 8'(src / 80) : (8'(src / 80) ^ 8'h80));
      end
      for (int k = 0; k < 160; k++) push_wr(BASE + 17'(3840 + k), (k % 2 == 0) ? 8'h20 : 8'h4E);
      send(8'h5A, 8'h4E);
      wait_idle(cyc);
      check("scroll_busy_cycles", 32'(cyc), 32'd7842);
      check("scroll_cursor", 32'(cursor), 32'd1919);
      check("scroll_cell0", 32'(ram[BASE]), 32'd1);
      check("scroll_Z_moved", 32'(ram[BASE + 17'(2 * 1919)]), 32'h5A);

      // Form feed clears the whole screen
      for (int k = 0; k < 4000; k++) push_wr(BASE + 17'(k), (k % 2 == 0) ? 8'h20 : 8'h07);
      send(8'h0C, 8'h07);
      wait_idle(cyc);
      check("cls_busy_cycles", 32'(cyc), 32'd4000);
      check("cls_cursor", 32'(cursor), 32'h7FF);

      // LF at row 24 starts a scroll; reset it during SCR_WR at k=100
      for (int i = 0; i < 24; i++) send(8'h0A, 8'h00);
      check("lf24_cursor", 32'(cursor), 32'd1919);
      for (int k = 0; k <= 100; k++) push_wr(BASE + 17'(k), (k % 2 == 0) ? 8'h20 : 8'h07);
      send(8'h0A, 8'h33);
      t = 0;
      while (!(bus.mem_we === 1'b1 && bus.mem_address === BASE + 17'd100) && t < 1000) begin
         @(negedge clock);
         t++;
      end
      check("scr_wr_k100_reached", 32'(t < 1000), 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("abort_mem_we", 32'(bus.mem_we), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_cursor", 32'(cursor), 32'h7FF);
      check("abort_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clock);
      check("pending_writes", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
